// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter slice: default widths,
// functional-unit index assignments and a small index-width helper.
package cdb_pkg;

    localparam int unsigned CDB_DATA_WIDTH = 32;
    localparam int unsigned CDB_TAG_WIDTH  = 7;
    localparam int unsigned CDB_NUM_FU     = 10;

    // Functional-unit positions on the fuValid/fuTag/fuData buses
    typedef enum logic [3:0] {
        FU_AND = 4'd0,
        FU_OR  = 4'd1,
        FU_XOR = 4'd2,
        FU_SLL = 4'd3,
        FU_SRL = 4'd4,
        FU_SRA = 4'd5,
        FU_MUL = 4'd6,
        FU_DIV = 4'd7,
        FU_SUB = 4'd8,
        FU_ADD = 4'd9,
        FU_NOP = 4'd15
    } fu_idx_e;

    // Bits needed to hold an index 0..n-1 (at least one bit)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Rotating-priority arbiter: grants the first requester found when scanning
// from ptr upward, wrapping from N-1 back to 0.
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned N = CDB_NUM_FU,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grantIdx,
    output logic          any
);

    int unsigned   cand;
    logic [IW-1:0] ci;

    // Scan candidates ptr, ptr+1, ... modulo N; first requester wins
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        any      = 1'b0;
        cand     = 0;
        ci       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            ci = IW'(cand);
            if (!any && req[ci]) begin
                any       = 1'b1;
                grant[ci] = 1'b1;
                grantIdx  = ci;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result slot per functional unit, round-robin
// selection of one slot per cycle, registered broadcast of tag and data.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CDB_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = CDB_TAG_WIDTH,
    parameter int unsigned NUM_FU     = CDB_NUM_FU
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_FU-1:0]            fuValid,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  fuTag,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fuData,
    output logic [NUM_FU-1:0]            fuReady,
    output logic                         dataAvailable,
    output logic [TAG_WIDTH-1:0]         destinationTag,
    output logic [DATA_WIDTH-1:0]        destinationData
);

    localparam int unsigned IW = idx_width(NUM_FU);

    logic [NUM_FU-1:0]     slotValid;
    logic [TAG_WIDTH-1:0]  slotTag  [NUM_FU];
    logic [DATA_WIDTH-1:0] slotData [NUM_FU];
    logic [NUM_FU-1:0]     arbReq;
    logic [NUM_FU-1:0]     grant;
    logic [IW-1:0]         grantIdx;
    logic                  grantAny;
    logic [IW-1:0]         rrPtr;

    // Flush suppresses all requests so no slot is granted in that cycle
    assign arbReq = flush ? '0 : slotValid;

    rr_arbiter #(
        .N (NUM_FU)
    ) u_rr (
        .req      (arbReq),
        .ptr      (rrPtr),
        .grant    (grant),
        .grantIdx (grantIdx),
        .any      (grantAny)
    );

    // A slot accepts when empty or being drained this cycle; flush blocks all
    always_comb begin
        fuReady = flush ? '0 : (~slotValid | grant);
    end

    // Slot occupancy: capture wins over drain so a same-cycle refill stays valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slotValid <= '0;
        end else if (flush) begin
            slotValid <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fuValid[i] && fuReady[i]) begin
                    slotValid[i] <= 1'b1;
                end else if (grant[i]) begin
                    slotValid[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payload storage, meaningful only while the slot is valid
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (fuValid[i] && fuReady[i]) begin
                slotTag[i]  <= fuTag[i*TAG_WIDTH +: TAG_WIDTH];
                slotData[i] <= fuData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Broadcast register and round-robin pointer advance on each grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataAvailable   <= 1'b0;
            destinationTag  <= '0;
            destinationData <= '0;
            rrPtr           <= '0;
        end else begin
            dataAvailable <= grantAny;
            if (grantAny) begin
                destinationTag  <= slotTag[grantIdx];
                destinationData <= slotData[grantIdx];
                rrPtr           <= (grantIdx == IW'(NUM_FU - 1)) ? '0 : grantIdx + 1'b1;
            end
        end
    end

endmodule
